// File: rtl/req_encoder_32x5.sv
// -----------------------------------------------------------------------------
// req_encoder_32x5
//
// Sequential 32-to-5 request encoder. Sticky request bits from 32 lines are
// collected in a pending register. One pending index at a time is presented
// to the consumer over a VALID/ACK handshake. The served bit is cleared when
// the consumer accepts it.
//
// Handshake: VALID=1 means IDX holds a pending request. A transfer happens on
// the rising edge where VALID=1 and ACK=1. While VALID=1 and ACK=0, IDX is
// held stable. ACK is ignored while VALID=0. VALID does not wait for ACK,
// and ACK may be high before VALID rises.
//
// Parameters
//   LSB_FIRST : 1 = the lowest pending index is served first,
//               0 = the highest pending index is served first.
//
// Ports
//   CLK   in   1  clock, all state changes on the rising edge
//   RESET in   1  synchronous, active-high reset
//   REQ   in  32  request lines, sampled every edge (level or pulse)
//   ACK   in   1  consumer accepts IDX (only meaningful while VALID=1)
//   IDX   out  5  encoded index being presented (registered)
//   VALID out  1  IDX holds a pending request (registered; this is the FSM
//                 state: 0 = IDLE, 1 = PRESENT)
//   PEND  out 32  pending-request register, including the presented bit
// -----------------------------------------------------------------------------
module req_encoder_32x5 #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] REQ,
   input  logic        ACK,
   output logic [4:0]  IDX,
   output logic        VALID,
   output logic [31:0] PEND
);

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic [31:0] pend_q, pend_d;

   logic        accept;
   logic [31:0] clr;
   logic [31:0] cand;
   logic        cand_any;
   logic [4:0]  sel;

   // Priority pick over a 32-bit vector. For lowest-first the scan runs
   // downward so the last hit is the lowest set bit; for highest-first it
   // runs upward so the last hit is the highest set bit.
   function automatic logic [4:0] pick(input logic [31:0] v);
      logic [4:0] r;
      r = '0;
      if (LSB_FIRST) begin
         for (int i = 31; i >= 0; i--) begin
            if (v[i]) r = 5'(i);
         end
      end else begin
         for (int i = 0; i < 32; i++) begin
            if (v[i]) r = 5'(i);
         end
      end
      return r;
   endfunction

   // Datapath: clear mask, pending update and candidate selection.
   always_comb begin
      accept = 1'b0;
      clr    = '0;
      if (state_q == ST_PRESENT && ACK) begin
         accept = 1'b1;
         clr    = 32'd1 << idx_q;
      end
      // REQ is OR-ed in after the clear so a same-edge request on the
      // acknowledged bit keeps it pending.
      pend_d   = (pend_q & ~clr) | REQ;
      // Candidates come only from the registered pending bits; requests
      // arriving on this edge are considered from the next cycle on.
      cand     = pend_q & ~clr;
      cand_any = |cand;
      sel      = pick(cand);
   end

   // Next-state logic for the IDLE/PRESENT handshake.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (cand_any) begin
               idx_d   = sel;
               state_d = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            if (accept) begin
               if (cand_any) begin
                  // Back-to-back: next index appears with no bubble.
                  idx_d = sel;
               end else begin
                  // IDX keeps its last value while idle.
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
      end
   end

   assign IDX   = idx_q;
   assign VALID = (state_q == ST_PRESENT);
   assign PEND  = pend_q;

endmodule

// File: tb/tb_req_encoder_32x5.sv
// -----------------------------------------------------------------------------
// tb_req_encoder_32x5
//
// Directed bench for req_encoder_32x5. Two instances share the same inputs:
// dut_l (lowest index first) and dut_m (highest index first). Inputs change
// 1 ns after a rising edge; outputs are sampled at that same point, after the
// registers have updated.
// -----------------------------------------------------------------------------
module tb_req_encoder_32x5;

   logic        CLK;
   logic        RESET;
   logic [31:0] REQ;
   logic        ACK;
   logic [4:0]  idx_l, idx_m;
   logic        valid_l, valid_m;
   logic [31:0] pend_l, pend_m;

   int n_vec;
   int n_err;

   // Clock / reset block
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   req_encoder_32x5 #(.LSB_FIRST(1'b1)) dut_l (
      .CLK   (CLK),
      .RESET (RESET),
      .REQ   (REQ),
      .ACK   (ACK),
      .IDX   (idx_l),
      .VALID (valid_l),
      .PEND  (pend_l)
   );

   req_encoder_32x5 #(.LSB_FIRST(1'b0)) dut_m (
      .CLK   (CLK),
      .RESET (RESET),
      .REQ   (REQ),
      .ACK   (ACK),
      .IDX   (idx_m),
      .VALID (valid_m),
      .PEND  (pend_m)
   );

   // Driver tasks
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Checker
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Watchdog: the sequence is fixed-length, so this only guards a stuck clock.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      RESET = 1'b1;
      REQ   = 32'hFFFF_FFFF;
      ACK   = 1'b0;

      // Reset with all requests high: REQ ignored during reset.
      steps(2);
      check("rst_pend",  pend_l, 32'h0);
      check("rst_valid", 32'(valid_l), 32'h0);
      check("rst_idx",   32'(idx_l), 32'h0);

      // Release reset: PEND fills after one edge, VALID one edge later.
      RESET = 1'b0;
      step();
      REQ = 32'h0;
      check("rel_pend",  pend_l, 32'hFFFF_FFFF);
      check("rel_valid0", 32'(valid_l), 32'h0);
      step();
      check("rel_valid1", 32'(valid_l), 32'h1);
      check("rel_idx",   32'(idx_l), 32'h0);
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      check("rst2_pend", pend_l, 32'h0);

      // Single request, held without ACK.
      REQ = 32'h0000_0400;
      step();
      REQ = 32'h0;
      check("single_pend",   pend_l, 32'h0000_0400);
      check("single_valid0", 32'(valid_l), 32'h0);
      step();
      check("single_valid1", 32'(valid_l), 32'h1);
      check("single_idx",    32'(idx_l), 32'd10);
      steps(3);
      check("single_hold_valid", 32'(valid_l), 32'h1);
      check("single_hold_idx",   32'(idx_l), 32'd10);
      ACK = 1'b1;
      step();
      ACK = 1'b0;
      check("single_ack_valid", 32'(valid_l), 32'h0);
      check("single_ack_pend",  pend_l, 32'h0);
      check("single_ack_idx",   32'(idx_l), 32'd10);

      // Hold stability: lower-index request arrives while 10 is presented.
      REQ = 32'h0000_0400;
      step();
      REQ = 32'h0;
      step();
      check("hold_idx10", 32'(idx_l), 32'd10);
      REQ = 32'h0000_0008;
      step();
      REQ = 32'h0;
      check("hold_idx_stays", 32'(idx_l), 32'd10);
      check("hold_pend",      pend_l, 32'h0000_0408);
      step();
      check("hold_idx_stays2", 32'(idx_l), 32'd10);
      ACK = 1'b1;
      step();
      check("hold_next_idx",   32'(idx_l), 32'd3);
      check("hold_next_valid", 32'(valid_l), 32'h1);
      check("hold_next_pend",  pend_l, 32'h0000_0008);
      step();
      check("hold_drain_valid", 32'(valid_l), 32'h0);
      check("hold_drain_pend",  pend_l, 32'h0);

      // ACK while idle has no effect.
      step();
      ACK = 1'b0;
      check("idle_ack_valid", 32'(valid_l), 32'h0);
      check("idle_ack_pend",  pend_l, 32'h0);

      // Back-to-back drain, both priority orders at once.
      REQ = 32'h8000_0005;
      step();
      REQ = 32'h0;
      ACK = 1'b1;
      check("b2b_pend", pend_l, 32'h8000_0005);
      step();
      check("b2b_l0", 32'(idx_l), 32'd0);
      check("b2b_m0", 32'(idx_m), 32'd31);
      check("b2b_v0", 32'(valid_l), 32'h1);
      step();
      check("b2b_l1", 32'(idx_l), 32'd2);
      check("b2b_m1", 32'(idx_m), 32'd2);
      check("b2b_pend_l1", pend_l, 32'h8000_0004);
      check("b2b_pend_m1", pend_m, 32'h0000_0005);
      step();
      check("b2b_l2", 32'(idx_l), 32'd31);
      check("b2b_m2", 32'(idx_m), 32'd0);
      check("b2b_v2", 32'(valid_m), 32'h1);
      step();
      ACK = 1'b0;
      check("b2b_end_vl", 32'(valid_l), 32'h0);
      check("b2b_end_vm", 32'(valid_m), 32'h0);
      check("b2b_end_il", 32'(idx_l), 32'd31);
      check("b2b_end_pend", pend_l, 32'h0);

      // Set wins over clear on the acknowledged bit.
      REQ = 32'h0000_0080;
      step();
      REQ = 32'h0;
      step();
      check("sw_idx7", 32'(idx_l), 32'd7);
      ACK = 1'b1;
      REQ = 32'h0000_0080;
      step();
      ACK = 1'b0;
      REQ = 32'h0;
      check("sw_pend_kept", pend_l, 32'h0000_0080);
      check("sw_valid_gap", 32'(valid_l), 32'h0);
      step();
      check("sw_repr_valid", 32'(valid_l), 32'h1);
      check("sw_repr_idx",   32'(idx_l), 32'd7);
      ACK = 1'b1;
      step();
      ACK = 1'b0;
      check("sw_final_pend",  pend_l, 32'h0);
      check("sw_final_valid", 32'(valid_l), 32'h0);

      // Reset in the middle of a presentation.
      REQ = 32'h0000_00F0;
      step();
      REQ = 32'h0;
      step();
      check("mid_idx",   32'(idx_l), 32'd4);
      check("mid_valid", 32'(valid_l), 32'h1);
      check("mid_pend",  pend_l, 32'h0000_00F0);
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      check("mid_rst_pend",  pend_l, 32'h0);
      check("mid_rst_valid", 32'(valid_l), 32'h0);
      check("mid_rst_idx",   32'(idx_l), 32'h0);
      steps(3);
      check("mid_quiet_valid", 32'(valid_l), 32'h0);
      check("mid_quiet_m",     32'(valid_m), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/req_encoder_32x5.md
# req_encoder_32x5

Sequential 32-to-5 request encoder: the inverse of the 5x32 line decoder used for register-file write select. It accumulates sticky request bits from 32 lines and presents one encoded 5-bit index at a time over a VALID/ACK handshake. Each served bit is cleared on acknowledge. The block sits between interrupt/exception sources (or register-scoreboard release lines) and the control unit, which consumes one index per handshake.

## Interface
- LSB_FIRST, default 1: 1 = lowest pending index has priority; 0 = highest pending index has priority.

- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  reset, synchronous and active-high.
- REQ  input  32  request lines; each bit sampled every rising edge; level or pulse both accepted.
- ACK  input  1  consumer accepts the presented index; meaningful only while VALID=1.
- IDX  output  5  encoded index being presented; registered.
- VALID  output  1  IDX holds a pending request; registered.
- PEND  output  32  pending-request register, including the bit currently presented.

## Operation
- State: PEND[31:0], IDX[4:0], VALID. VALID=0 is the IDLE state; VALID=1 is the PRESENT state.
- Reset (RESET=1 at an edge): PEND=0, IDX=0, VALID=0. REQ is ignored on that edge. A reset mid-handshake discards all pending and presented requests without acknowledge.
- Pending update every non-reset edge: PEND_next = (PEND & ~clr) | REQ.
  - clr is the one-hot of IDX when VALID&ACK; otherwise clr=0.
  - Set wins over clear: a REQ bit equal to the acknowledged IDX on the same edge leaves that bit pending. It is presented again later.
- Selection: sel = priority pick (per LSB_FIRST) over cand.
  - cand = PEND in IDLE.
  - cand = PEND & ~onehot(IDX) in PRESENT with ACK.
  - REQ bits arriving on the current edge are never candidates until the next cycle.
- IDLE: if cand≠0, load IDX=sel and set VALID=1. Otherwise stay IDLE with IDX unchanged.
- PRESENT, ACK=0: IDX and VALID hold, even if a higher-priority request arrives. The new request waits.
- PRESENT, ACK=1:
  - if cand≠0, load IDX=sel and keep VALID=1 (back-to-back, no bubble);
  - else VALID=0 and IDX holds its last value.
- ACK while VALID=0 is ignored; no bit is cleared.
- Only PEND stores requests. Repeated REQ on an already-pending bit has no additional effect; there is no counting.

## Timing
- Request latency: REQ bit high at edge n → PEND bit set after edge n → VALID=1 with IDX after edge n+1. Minimum 2 cycles from sampling to presentation.
- Handshake completes on the edge where VALID=1 and ACK=1. The next index is visible 1 cycle later when other requests are pending. Sustained throughput is one index per cycle.
- IDX is stable for the whole interval VALID=1, ACK=0.
- PEND reflects the cleared bit on the cycle after the accepting edge.
- All outputs come directly from registers; there is no combinational path from REQ or ACK to any output.

## Test plan
- Reset: drive REQ=32'hFFFFFFFF with RESET=1 for 2 edges → PEND=0, VALID=0, IDX=0. Release RESET → VALID rises 2 edges later with IDX=0 (LSB_FIRST=1).
- Single request: pulse REQ=32'h0000_0400 for 1 cycle, hold ACK=0 → VALID=1, IDX=10, held indefinitely. Assert ACK 1 cycle → VALID=0 next cycle, PEND=0.
- Back-to-back drain: pulse REQ=32'h8000_0005, then hold ACK=1 → IDX sequence 0, 2, 31 on consecutive cycles, then VALID=0. With LSB_FIRST=0 the order is 31, 2, 0.
- Hold stability: present IDX=10 with ACK=0, then pulse REQ bit 3 → IDX stays 10. On ACK the next IDX=3.
- Set-wins collision: present IDX=7, assert ACK and REQ bit 7 on the same edge → PEND[7] still 1. IDX=7 is re-presented (next cycle if no other bits are pending).
- Reset mid-operation: PEND=32'h0000_00F0 with VALID=1 and IDX=4, assert RESET 1 edge → all outputs 0, no further VALID until new REQ.
